salsa20_round_unit: RTL and testbench
=====================================

// Module: salsa20_round_unit
// PURPOSE
// - One Salsa20 round datapath for the 20-round hash core.
// - Computes both the column round ("odd" round) and the row round ("even" round) combinationally from one 512-bit state.
// - Also provides a registered, selectable result so the hash FSM can iterate 20 rounds, odd first.
// PARAMETERS
// - none (state fixed at 16 x 32-bit words)
// PORTS
// clk       in   1    clock, rising edge
// reset     in   1    synchronous, active-high; clears registered outputs
// in_valid  in   1    capture a round result this cycle
// round_sel in   1    0 = column (odd) round, 1 = row (even) round
// data_in   in   512  state; word xi = data_in[32*i+31 : 32*i], x0 at LSBs
// odd_out   out  512  combinational column round of data_in, same packing
// even_out  out  512  combinational row round of data_in, same packing
// data_out  out  512  registered selected round result
// out_valid out  1    data_out updated on previous edge
// BEHAVIOUR
// - Quarterround QR(a,b,c,d), sequential, each step uses updated values:
//   - b ^= rotl32(a+d, 7)
//   - c ^= rotl32(b+a, 9)
//   - d ^= rotl32(c+b, 13)
//   - a ^= rotl32(d+c, 18)
//   - "+" is mod 2^32 (carry out discarded); rotl32 is a 32-bit left rotate.
// - Column round (odd_out), four independent QRs, results written back to the same word slots:
//   - QR(x0,x4,x8,x12)
//   - QR(x5,x9,x13,x1)
//   - QR(x10,x14,x2,x6)
//   - QR(x15,x3,x7,x11)
// - Row round (even_out), same write-back rule:
//   - QR(x0,x1,x2,x3)
//   - QR(x5,x6,x7,x4)
//   - QR(x10,x11,x8,x9)
//   - QR(x15,x12,x13,x14)
// - odd_out and even_out:
//   - purely combinational, zero latency
//   - independent of clk, reset and in_valid
// - Registered path: on each rising clk edge
//   - if reset: data_out <= 0, out_valid <= 0
//   - else if in_valid: data_out <= round_sel ? even_out : odd_out, out_valid <= 1
//   - else: data_out holds, out_valid <= 0
// - Latency 1 cycle; throughput one round per cycle. Back-to-back in_valid is allowed.
// - No internal state other than data_out and out_valid; no FSM.
// - Reset while in_valid=1: reset wins and nothing is captured.
// - Hash usage: 20 rounds, alternating column, row, column, ... (10 double rounds).
//   - Final feed-forward addition is done by the caller, not here.
// - Power-up value of the registered outputs is undefined until the first reset.
// TESTING
// - All-zero state:
//   - expect odd_out = even_out = 0.
//   - After in_valid with either round_sel: data_out = 0, out_valid = 1.
// - QR vector: x0=0x00000001, all other words 0, row round:
//   - x0..x3 = 08008145, 00000080, 00010200, 20500000
//   - all other words 0
// - Row round, x0=x4=x8=x12=0x00000001, others 0. Expected even_out x0..x15:
//   - 08008145 00000080 00010200 20500000
//   - 20100001 00048044 00000080 00010000
//   - 00000001 00002000 80040000 00000000
//   - 00000001 00000200 00402000 88000100
// - Column round, same input. Expected odd_out x0..x15:
//   - 10090288 0 0 0
//   - 00000101 0 0 0
//   - 00020401 0 0 0
//   - 40a04001 0 0 0
// - Register path, same input:
//   - round_sel=0, in_valid=1 -> next cycle data_out = odd_out vector, out_valid = 1
//   - then in_valid=0 -> data_out holds, out_valid = 0
// - Reset asserted together with in_valid=1 -> next cycle data_out = 0, out_valid = 0.

Source files
------------

// File: rtl/salsa20_round_unit.sv
// rtl/salsa20_round_unit.sv - Salsa20 column/row round datapath with one registered, selectable result
// salsa20_qr is the shared quarterround; salsa20_round_unit wires eight of them and registers the chosen round.

module salsa20_qr (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);
    logic [31:0] sum_b;
    logic [31:0] sum_c;
    logic [31:0] sum_d;
    logic [31:0] sum_a;

    // Each step feeds on the words already updated by the previous step.
    assign sum_b = a_in + d_in;
    assign b_out = b_in ^ {sum_b[24:0], sum_b[31:25]};
    assign sum_c = b_out + a_in;
    assign c_out = c_in ^ {sum_c[22:0], sum_c[31:23]};
    assign sum_d = c_out + b_out;
    assign d_out = d_in ^ {sum_d[18:0], sum_d[31:19]};
    assign sum_a = d_out + c_out;
    assign a_out = a_in ^ {sum_a[13:0], sum_a[31:14]};
endmodule

module salsa20_round_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         round_sel,
    input  logic [511:0] data_in,
    output logic [511:0] odd_out,
    output logic [511:0] even_out,
    output logic [511:0] data_out,
    output logic         out_valid
);
    logic [31:0] x   [16];
    logic [31:0] col [16];
    logic [31:0] row [16];

    for (genvar i = 0; i < 16; i++) begin : g_words
        assign x[i]                = data_in[32*i +: 32];
        assign odd_out[32*i +: 32]  = col[i];
        assign even_out[32*i +: 32] = row[i];
    end

    salsa20_qr u_col0 (.a_in(x[0]),  .b_in(x[4]),  .c_in(x[8]),  .d_in(x[12]),
                       .a_out(col[0]),  .b_out(col[4]),  .c_out(col[8]),  .d_out(col[12]));
    salsa20_qr u_col1 (.a_in(x[5]),  .b_in(x[9]),  .c_in(x[13]), .d_in(x[1]),
                       .a_out(col[5]),  .b_out(col[9]),  .c_out(col[13]), .d_out(col[1]));
    salsa20_qr u_col2 (.a_in(x[10]), .b_in(x[14]), .c_in(x[2]),  .d_in(x[6]),
                       .a_out(col[10]), .b_out(col[14]), .c_out(col[2]),  .d_out(col[6]));
    salsa20_qr u_col3 (.a_in(x[15]), .b_in(x[3]),  .c_in(x[7]),  .d_in(x[11]),
                       .a_out(col[15]), .b_out(col[3]),  .c_out(col[7]),  .d_out(col[11]));

    salsa20_qr u_row0 (.a_in(x[0]),  .b_in(x[1]),  .c_in(x[2]),  .d_in(x[3]),
                       .a_out(row[0]),  .b_out(row[1]),  .c_out(row[2]),  .d_out(row[3]));
    salsa20_qr u_row1 (.a_in(x[5]),  .b_in(x[6]),  .c_in(x[7]),  .d_in(x[4]),
                       .a_out(row[5]),  .b_out(row[6]),  .c_out(row[7]),  .d_out(row[4]));
    salsa20_qr u_row2 (.a_in(x[10]), .b_in(x[11]), .c_in(x[8]),  .d_in(x[9]),
                       .a_out(row[10]), .b_out(row[11]), .c_out(row[8]),  .d_out(row[9]));
    salsa20_qr u_row3 (.a_in(x[15]), .b_in(x[12]), .c_in(x[13]), .d_in(x[14]),
                       .a_out(row[15]), .b_out(row[12]), .c_out(row[13]), .d_out(row[14]));

    // Reset outranks a simultaneous capture request.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= round_sel ? even_out : odd_out;
            end
        end
    end
endmodule

// File: tb/tb_salsa20_round_unit.sv
// tb/tb_salsa20_round_unit.sv - self-checking bench for salsa20_round_unit against a table-driven round model
module tb_salsa20_round_unit;
    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         round_sel;
    logic [511:0] data_in;
    logic [511:0] odd_out;
    logic [511:0] even_out;
    logic [511:0] data_out;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    salsa20_round_unit dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .round_sel(round_sel),
        .data_in  (data_in),
        .odd_out  (odd_out),
        .even_out (even_out),
        .data_out (data_out),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [511:0] ONE_COLS = {32'h1, 96'h0, 32'h1, 96'h0, 32'h1, 96'h0, 32'h1};
    localparam logic [511:0] EXP_ROW_QR = {384'h0, 32'h20500000, 32'h00010200, 32'h00000080, 32'h08008145};
    localparam logic [511:0] EXP_ROW = {
        32'h88000100, 32'h00402000, 32'h00000200, 32'h00000001,
        32'h00000000, 32'h80040000, 32'h00002000, 32'h00000001,
        32'h00010000, 32'h00000080, 32'h00048044, 32'h20100001,
        32'h20500000, 32'h00010200, 32'h00000080, 32'h08008145};
    localparam logic [511:0] EXP_COL = {
        96'h0, 32'h40a04001, 96'h0, 32'h00020401,
        96'h0, 32'h00000101, 96'h0, 32'h10090288};

    function automatic bit [31:0] rotl(input bit [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] model_round(input logic [511:0] s, input bit is_row);
        bit [31:0] w [16];
        int        t [16];
        logic [511:0] r;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
        if (is_row) t = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
        else        t = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
        for (int q = 0; q < 4; q++) begin
            a = t[4*q]; b = t[4*q+1]; c = t[4*q+2]; d = t[4*q+3];
            w[b] = w[b] ^ rotl(w[a] + w[d], 7);
            w[c] = w[c] ^ rotl(w[b] + w[a], 9);
            w[d] = w[d] ^ rotl(w[c] + w[b], 13);
            w[a] = w[a] ^ rotl(w[d] + w[c], 18);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; round_sel = 1'b0; data_in = '0;
        tick(); tick();
        n_checks++;
        if (data_out !== 512'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_out); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_state();
        for (int sel = 0; sel < 2; sel++) begin
            data_in = rand_state(); in_valid = 1'b1; round_sel = 1'b0;
            tick();
            data_in = '0; in_valid = 1'b1; round_sel = sel[0];
            #1;
            n_checks++;
            if (odd_out !== 512'h0 || even_out !== 512'h0) begin
                n_fail++; $display("FAIL zero_comb: odd %h even %h expected 0", odd_out, even_out);
            end
            tick();
            n_checks++;
            if (data_out !== 512'h0 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL zero_reg sel=%0d: got %h valid %b expected 0 valid 1", sel, data_out, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_vectors();
        data_in = 512'h1; #1;
        n_checks++;
        if (even_out !== EXP_ROW_QR) begin n_fail++; $display("FAIL qr_vector: got %h expected %h", even_out, EXP_ROW_QR); end
        data_in = ONE_COLS; #1;
        n_checks++;
        if (even_out !== EXP_ROW) begin n_fail++; $display("FAIL row_vector: got %h expected %h", even_out, EXP_ROW); end
        n_checks++;
        if (odd_out !== EXP_COL) begin n_fail++; $display("FAIL col_vector: got %h expected %h", odd_out, EXP_COL); end
    endtask

    task automatic test_register_path();
        data_in = ONE_COLS; round_sel = 1'b0; in_valid = 1'b1;
        tick();
        n_checks++;
        if (data_out !== EXP_COL || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL reg_capture: got %h valid %b expected %h valid 1", data_out, out_valid, EXP_COL);
        end
        in_valid = 1'b0; data_in = rand_state(); round_sel = 1'b1;
        tick();
        n_checks++;
        if (data_out !== EXP_COL || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reg_hold: got %h valid %b expected %h valid 0", data_out, out_valid, EXP_COL);
        end
    endtask

    task automatic test_reset_with_valid();
        logic [511:0] s;
        s = rand_state();
        data_in = s; round_sel = 1'b1; in_valid = 1'b1; reset = 1'b1;
        #1;
        n_checks++;
        if (odd_out !== model_round(s, 1'b0)) begin
            n_fail++; $display("FAIL comb_during_reset: got %h expected %h", odd_out, model_round(s, 1'b0));
        end
        tick();
        n_checks++;
        if (data_out !== 512'h0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_wins: got %h valid %b expected 0 valid 0", data_out, out_valid);
        end
        reset = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random_comb();
        logic [511:0] s;
        for (int k = 0; k < 20; k++) begin
            s = rand_state();
            data_in = s;
            #1;
            n_checks++;
            if (odd_out !== model_round(s, 1'b0)) begin
                n_fail++; $display("FAIL rand_odd %0d: got %h expected %h", k, odd_out, model_round(s, 1'b0));
            end
            n_checks++;
            if (even_out !== model_round(s, 1'b1)) begin
                n_fail++; $display("FAIL rand_even %0d: got %h expected %h", k, even_out, model_round(s, 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] exp_data;
        bit           exp_valid;
        exp_data = data_out;
        for (int k = 0; k < 40; k++) begin
            data_in   = rand_state();
            round_sel = $urandom_range(0, 1);
            in_valid  = ($urandom_range(0, 3) != 0);
            exp_valid = in_valid;
            if (in_valid) exp_data = model_round(data_in, round_sel);
            tick();
            n_checks++;
            if (data_out !== exp_data || out_valid !== exp_valid) begin
                n_fail++; $display("FAIL b2b %0d: got %h valid %b expected %h valid %b", k, data_out, out_valid, exp_data, exp_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hash_20_rounds();
        logic [511:0] exp_state;
        logic [511:0] cur;
        cur = rand_state();
        exp_state = cur;
        for (int k = 0; k < 20; k++) exp_state = model_round(exp_state, k[0]);
        for (int k = 0; k < 20; k++) begin
            data_in = cur; round_sel = k[0]; in_valid = 1'b1;
            tick();
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hash_valid %0d: got %b expected 1", k, out_valid); end
            cur = data_out;
        end
        in_valid = 1'b0;
        n_checks++;
        if (data_out !== exp_state) begin n_fail++; $display("FAIL hash_20: got %h expected %h", data_out, exp_state); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; round_sel = 1'b0; data_in = '0;
        test_reset();
        test_zero_state();
        test_vectors();
        test_register_path();
        test_reset_with_valid();
        test_random_comb();
        test_back_to_back();
        test_hash_20_rounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
